// File: rtl/wb_rd_stream_if.sv
// ---------------------------------------------------------------------------
// wb_rd_stream_if
// Groups the Wishbone classic read bus and the output valid/ready stream
// of wb_rd_stream.
//   master modport : the read engine (drives cyc/stb/adr, the stream data
//                    and out_valid; receives dat_sm, ack and out_ready)
//   slave modport  : the bus slave and the stream consumer
// Parameter ADR_W : Wishbone word-address width.
// ---------------------------------------------------------------------------
interface wb_rd_stream_if #(
    parameter int ADR_W = 11
) ();
    logic             wb_cyc;
    logic             wb_stb;
    logic             wb_we;
    logic [3:0]       wb_sel;
    logic [ADR_W-1:0] wb_adr;
    logic [31:0]      wb_dat_ms;
    logic [31:0]      wb_dat_sm;
    logic             wb_ack;
    logic [31:0]      out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_dat_ms,
        input  wb_dat_sm, wb_ack,
        output out_data, out_valid,
        input  out_ready
    );

    modport slave (
        input  wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_dat_ms,
        output wb_dat_sm, wb_ack,
        input  out_data, out_valid,
        output out_ready
    );
endinterface

// File: rtl/wb_rd_stream.sv
// ---------------------------------------------------------------------------
// wb_rd_stream
// Wishbone classic read master: on start it reads len consecutive 32-bit
// words from base_adr (one single read per transfer) into a small
// first-word-fall-through FIFO that drives a valid/ready output stream.
// A one-cycle GAP after every ack absorbs the block RAM's trailing ack.
//
// Ports:
//   clk       : clock, rising edge
//   rst       : asynchronous active-low reset
//   start     : one-cycle command, sampled only when idle
//   base_adr  : first word address (latched on start)
//   len       : number of words (latched on start); 0 -> immediate done
//   busy      : transfer in progress
//   done      : one-cycle pulse at the end of a transfer
//   err       : sticky ack-timeout flag (constant 0 without the option)
//   bus       : wb_rd_stream_if.master (Wishbone bus + output stream)
//
// Optional feature macro: WB_RD_STREAM_TIMEOUT_EN
//   When defined, a REQ that sees no qualified ack within TIMEOUT cycles
//   is abandoned, err is set, and the transfer finishes through FLUSH.
// ---------------------------------------------------------------------------
module wb_rd_stream #(
    parameter int ADR_W      = 11,
    parameter int LEN_W      = 12,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [ADR_W-1:0]   base_adr,
    input  logic [LEN_W-1:0]   len,
    output logic               busy,
    output logic               done,
    output logic               err,
    wb_rd_stream_if.master     bus
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ISSUE = 3'd1;
    localparam logic [2:0] REQ   = 3'd2;
    localparam logic [2:0] GAP   = 3'd3;
    localparam logic [2:0] FLUSH = 3'd4;

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [2:0]       state_q, state_d;
    logic [ADR_W-1:0] adr_q, adr_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      fifo_mem [FIFO_DEPTH];

    logic push;
    logic pop;

    // An ack only counts while stb is high; stb is high exactly in REQ.
    assign push = (state_q == REQ) && bus.wb_ack;
    assign pop  = (count_q != '0) && bus.out_ready;

    assign bus.wb_cyc    = (state_q == REQ);
    assign bus.wb_stb    = (state_q == REQ);
    assign bus.wb_we     = 1'b0;
    assign bus.wb_sel    = 4'hF;
    assign bus.wb_dat_ms = 32'h0;
    assign bus.wb_adr    = adr_q;
    assign bus.out_valid = (count_q != '0);
    assign bus.out_data  = fifo_mem[rd_ptr_q];

    assign busy = busy_q;
    assign done = done_q;

`ifdef WB_RD_STREAM_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             err_q, err_d;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // ---------------- control FSM ----------------
    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        rem_d   = rem_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef WB_RD_STREAM_TIMEOUT_EN
        err_d   = err_q;
        tmr_d   = '0;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        adr_d   = base_adr;
                        rem_d   = len;
                        busy_d  = 1'b1;
                        state_d = ISSUE;
`ifdef WB_RD_STREAM_TIMEOUT_EN
                        err_d   = 1'b0;
`endif
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ISSUE: begin
                // Only one read is ever outstanding, so a free slot now
                // guarantees room for the word when it arrives.
                if (count_q < CNT_W'(FIFO_DEPTH)) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (bus.wb_ack) begin
                    adr_d   = adr_q + 1'b1;
                    rem_d   = rem_q - 1'b1;
                    state_d = GAP;
                end
`ifdef WB_RD_STREAM_TIMEOUT_EN
                else if (tmr_q == TMR_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = FLUSH;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
`endif
            end
            GAP: begin
                state_d = (rem_q != '0) ? ISSUE : FLUSH;
            end
            FLUSH: begin
                if (count_q == '0) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // ---------------- FIFO pointers ----------------
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            adr_q    <= '0;
            rem_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
`ifdef WB_RD_STREAM_TIMEOUT_EN
            err_q    <= 1'b0;
            tmr_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            adr_q    <= adr_d;
            rem_q    <= rem_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
`ifdef WB_RD_STREAM_TIMEOUT_EN
            err_q    <= err_d;
            tmr_q    <= tmr_d;
`endif
        end
    end

    // Storage needs no reset: an entry is only visible once count covers it.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= bus.wb_dat_sm;
        end
    end

endmodule
